// File: rtl/nand_apb_pkg.sv
// Shared register map, busy bit and state encodings for the NAND APB job sequencer.
package nand_apb_pkg;
  localparam logic [15:0] ADDR_DATA   = 16'h0000;
  localparam logic [15:0] ADDR_CMD    = 16'h0004;
  localparam logic [15:0] ADDR_STATUS = 16'h000C;
  localparam int          BUSY_BIT    = 0;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_DATA, S_WR_CMD, S_SETTLE, S_POLL, S_RD_DATA, S_PUSH, S_FIN
  } seq_state_e;

  typedef enum logic [1:0] {X_IDLE, X_SETUP, X_ACCESS} xfer_state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic        write;
    logic [31:0] wdata;
  } xfer_req_t;

  function automatic logic [31:0] pad_byte(input logic [7:0] b);
    return {24'h0, b};
  endfunction
endpackage

// File: rtl/nand_apb_xfer.sv
// Single APB transfer engine: latches a request on start, runs SETUP then ACCESS until PREADY.
module nand_apb_xfer
  import nand_apb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] addr_i,
  input  logic        write_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        cmplt_o,
  output logic [31:0] rdata_o,
  output logic        slverr_o,
  output logic [15:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);
  xfer_state_e xs_q, xs_d;
  xfer_req_t   req_q, req_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      xs_q  <= X_IDLE;
      req_q <= '0;
    end else begin
      xs_q  <= xs_d;
      req_q <= req_d;
    end
  end

  always_comb begin
    xs_d  = xs_q;
    req_d = req_q;
    unique case (xs_q)
      X_IDLE: if (start_i) begin
        xs_d        = X_SETUP;
        req_d.addr  = addr_i;
        req_d.write = write_i;
        req_d.wdata = wdata_i;
      end
      X_SETUP:  xs_d = X_ACCESS;
      X_ACCESS: if (pready_i) xs_d = X_IDLE;
      default:  xs_d = X_IDLE;
    endcase
  end

  // Bus outputs decode straight from registered state so reset drops PSEL immediately.
  assign busy_o    = (xs_q != X_IDLE);
  assign psel_o    = (xs_q != X_IDLE);
  assign penable_o = (xs_q == X_ACCESS);
  assign paddr_o   = req_q.addr;
  assign pwrite_o  = req_q.write;
  assign pwdata_o  = req_q.wdata;
  assign cmplt_o   = penable_o & pready_i;
  assign rdata_o   = prdata_i;
  assign slverr_o  = cmplt_o & pslverr_i;
endmodule

// File: rtl/nand_apb_seq.sv
// NAND controller job sequencer: DATA/CMD writes, settle, STATUS polling, DATA read-out
// into a valid/ready byte stream, with done/err completion pulses.
module nand_apb_seq
  import nand_apb_pkg::*;
#(
  parameter int POLL_LIMIT = 1024,
  parameter int SETTLE_CYC = 4
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic        job_wr,
  input  logic [7:0]  job_wdata,
  input  logic [7:0]  job_cmd,
  input  logic [15:0] job_rd_len,
  output logic [15:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  input  logic        rd_ready,
  output logic        done,
  output logic        err
);
  localparam int              PW          = $clog2(POLL_LIMIT + 1);
  localparam logic [PW-1:0]   POLL_LAST   = PW'(POLL_LIMIT - 1);
  localparam logic [15:0]     SETTLE_LAST = (SETTLE_CYC > 0) ? 16'(SETTLE_CYC - 1) : 16'd0;

  seq_state_e    state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [15:0]   rem_q, rem_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [7:0]    rdd_q, rdd_d;

  logic          x_start, x_write, x_busy, x_cmplt, x_slverr;
  logic [15:0]   x_addr;
  logic [31:0]   x_wdata, x_rdata;
  logic          unused_rdata;

  assign unused_rdata = ^x_rdata[31:8];

  nand_apb_xfer u_xfer (
    .clk_i    (PCLK),
    .rst_i    (PRESET),
    .start_i  (x_start),
    .addr_i   (x_addr),
    .write_i  (x_write),
    .wdata_i  (x_wdata),
    .busy_o   (x_busy),
    .cmplt_o  (x_cmplt),
    .rdata_o  (x_rdata),
    .slverr_o (x_slverr),
    .paddr_o  (PADDR),
    .psel_o   (PSEL),
    .penable_o(PENABLE),
    .pwrite_o (PWRITE),
    .pwdata_o (PWDATA),
    .prdata_i (PRDATA),
    .pready_i (PREADY),
    .pslverr_i(PSLVERR)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      rem_q   <= '0;
      poll_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdd_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rem_q   <= rem_d;
      poll_q  <= poll_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdd_q   <= rdd_d;
    end
  end

  // A transfer state issues start whenever the engine is idle; the engine's idle cycle after
  // each completion provides the mandatory bus gap. IDLE issues the first write on accept.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rem_d   = rem_q;
    poll_d  = poll_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdd_d   = rdd_q;
    x_start = 1'b0;
    x_addr  = ADDR_CMD;
    x_write = 1'b0;
    x_wdata = '0;
    unique case (state_q)
      S_IDLE: if (job_valid) begin
        x_start = 1'b1;
        x_write = 1'b1;
        x_addr  = job_wr ? ADDR_DATA : ADDR_CMD;
        x_wdata = pad_byte(job_wr ? job_wdata : job_cmd);
        cmd_d   = job_cmd;
        rem_d   = job_rd_len;
        poll_d  = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = job_wr ? S_WR_DATA : S_WR_CMD;
      end
      S_WR_DATA: if (x_cmplt) state_d = S_WR_CMD;
      S_WR_CMD: begin
        x_start = !x_busy;
        x_write = 1'b1;
        x_addr  = ADDR_CMD;
        x_wdata = pad_byte(cmd_q);
        if (x_cmplt) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q >= SETTLE_LAST) state_d = S_POLL;
      end
      S_POLL: begin
        x_start = !x_busy;
        x_addr  = ADDR_STATUS;
        if (x_cmplt) begin
          poll_d = poll_q + PW'(1);
          if (x_rdata[BUSY_BIT]) begin
            if (poll_q == POLL_LAST) begin
              err_d   = 1'b1;
              state_d = S_FIN;
            end
          end else begin
            state_d = (rem_q != 16'd0) ? S_RD_DATA : S_FIN;
          end
        end
      end
      S_RD_DATA: begin
        x_start = !x_busy;
        x_addr  = ADDR_DATA;
        if (x_cmplt) begin
          rdd_d   = x_rdata[7:0];
          state_d = S_PUSH;
        end
      end
      S_PUSH: if (rd_ready) begin
        rem_d   = rem_q - 16'd1;
        state_d = (rem_q == 16'd1) ? S_FIN : S_RD_DATA;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Slave error on any transfer aborts the job regardless of phase.
    if (x_slverr) begin
      err_d   = 1'b1;
      state_d = S_FIN;
    end
  end

  assign job_ready = (state_q == S_IDLE) & ~PRESET;
  assign rd_valid  = (state_q == S_PUSH);
  assign rd_data   = rdd_q;
  assign done      = (state_q == S_FIN);
  assign err       = done & err_q;
endmodule

// File: tb/tb_nand_apb_seq.sv
// Self-checking bench for nand_apb_seq: APB completer model, byte-stream sink, queued expectations.
module tb_nand_apb_seq;
  import nand_apb_pkg::*;

  logic        PCLK = 1'b0, PRESET = 1'b1;
  logic        job_valid = 1'b0, job_wr = 1'b0, job_ready;
  logic [7:0]  job_wdata = '0, job_cmd = '0;
  logic [15:0] job_rd_len = '0;
  logic [15:0] PADDR;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PWDATA, PRDATA;
  logic        rd_valid, rd_ready = 1'b1, done, err;
  logic [7:0]  rd_data;

  typedef struct { logic [15:0] addr; logic wr; logic [7:0] wd; } txn_t;
  txn_t        exp_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  data_arr[16];
  txn_t        mt;
  logic [7:0]  eb;

  int pass_cnt = 0, tot_cnt = 0, mon_pass = 0, mon_tot = 0;
  int wait_cyc = 0, busy_n = 0, st_base = 0, dat_base = 0;
  int st_cnt = 0, dat_cnt = 0, acc_cnt = 0;
  int stall_at = -1, stall_len = 0, byte_cnt = 0, cur_wait = 0;
  logic        err_en = 1'b0;
  logic [15:0] err_addr = '0;

  always #5 PCLK = ~PCLK;

  nand_apb_seq #(.POLL_LIMIT(8), .SETTLE_CYC(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .job_valid(job_valid), .job_ready(job_ready), .job_wr(job_wr),
    .job_wdata(job_wdata), .job_cmd(job_cmd), .job_rd_len(job_rd_len), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready), .done(done),
    .err(err)
  );

  assign PREADY  = PSEL && PENABLE && (acc_cnt >= wait_cyc);
  assign PSLVERR = PREADY && err_en && (PADDR == err_addr);
  assign PRDATA  = (PADDR == ADDR_STATUS) ? {31'h0, ((st_cnt - st_base) < busy_n)} :
                   (PADDR == ADDR_DATA)   ? {24'h0, data_arr[4'(dat_cnt - dat_base)]} : 32'h0;

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && PREADY) begin
      acc_cnt <= 0;
      if (!PWRITE && PADDR == ADDR_STATUS) st_cnt <= st_cnt + 1;
      if (!PWRITE && PADDR == ADDR_DATA) dat_cnt <= dat_cnt + 1;
    end else if (PSEL && PENABLE) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  // Scoreboard side: completed APB transfers and byte handshakes against queued expectations.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE && PREADY) begin
      mon_tot++;
      if (exp_q.size() == 0)
        $display("FAIL apb_unexpected: got addr=%h wr=%b wdata=%h, required no transfer", PADDR, PWRITE, PWDATA);
      else begin
        mt = exp_q.pop_front();
        if (PADDR !== mt.addr || PWRITE !== mt.wr || (mt.wr && PWDATA !== {24'h0, mt.wd}))
          $display("FAIL apb_txn: got addr=%h wr=%b wdata=%h, required addr=%h wr=%b wdata=%h",
                   PADDR, PWRITE, PWDATA, mt.addr, mt.wr, {24'h0, mt.wd});
        else mon_pass++;
      end
    end
    if (rd_valid) begin
      if (byte_cnt == stall_at && cur_wait < stall_len) begin
        rd_ready = 1'b0;
        cur_wait++;
        mon_tot++;
        if (rd_q.size() == 0 || rd_data !== rd_q[0])
          $display("FAIL stall_data: got %h, required %h", rd_data, (rd_q.size() != 0) ? rd_q[0] : 8'hxx);
        else mon_pass++;
        mon_tot++;
        if (PSEL !== 1'b0) $display("FAIL stall_apb_idle: got PSEL=%b, required 0", PSEL);
        else mon_pass++;
      end else begin
        rd_ready = 1'b1;
        cur_wait = 0;
        byte_cnt++;
        mon_tot++;
        if (rd_q.size() == 0) $display("FAIL rd_unexpected: got %h, required no byte", rd_data);
        else begin
          eb = rd_q.pop_front();
          if (rd_data !== eb) $display("FAIL rd_byte: got %h, required %h", rd_data, eb);
          else mon_pass++;
        end
      end
    end else rd_ready = 1'b1;
  end

  task automatic exp_apb(input logic [15:0] a, input logic w, input logic [7:0] d);
    txn_t t;
    t.addr = a; t.wr = w; t.wd = d;
    exp_q.push_back(t);
  endtask

  task automatic start_job(input logic wr, input logic [7:0] wd, input logic [7:0] cmd, input logic [15:0] len);
    int n = 0;
    @(negedge PCLK);
    while (!job_ready && n < 200) begin @(negedge PCLK); n++; end
    job_wr = wr; job_wdata = wd; job_cmd = cmd; job_rd_len = len; job_valid = 1'b1;
    @(posedge PCLK);
    #1 job_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic e, output logic ok);
    lat = 0; ok = 1'b0; e = 1'b0;
    while (!ok && lat < 3000) begin
      @(negedge PCLK);
      lat++;
      if (done) begin ok = 1'b1; e = err; end
    end
  endtask

  task automatic test_reset();
    @(negedge PCLK);
    tot_cnt++;
    if (job_ready !== 1'b0) $display("FAIL reset_job_ready: got %b, required 0", job_ready); else pass_cnt++;
    tot_cnt++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0)
      $display("FAIL reset_apb: got sel=%b en=%b wr=%b addr=%h wdata=%h, required all 0", PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    else pass_cnt++;
    tot_cnt++;
    if ({rd_valid, rd_data, done, err} !== '0)
      $display("FAIL reset_outs: got rd_valid=%b rd_data=%h done=%b err=%b, required 0", rd_valid, rd_data, done, err);
    else pass_cnt++;
    PRESET = 1'b0;
    @(negedge PCLK);
    tot_cnt++;
    if (job_ready !== 1'b1) $display("FAIL reset_release_ready: got %b, required 1", job_ready); else pass_cnt++;
  endtask

  task automatic test_latency();
    int lat; logic e, ok;
    busy_n = 0; st_base = st_cnt; wait_cyc = 0;
    exp_apb(ADDR_CMD, 1'b1, 8'h30);
    exp_apb(ADDR_STATUS, 1'b0, 8'h00);
    start_job(1'b0, 8'h00, 8'h30, 16'd0);
    wait_done(lat, e, ok);
    tot_cnt++; if (!ok) $display("FAIL lat_done_seen: got timeout, required done"); else pass_cnt++;
    tot_cnt++; if (lat != 10) $display("FAIL lat_cycles: got %0d, required 10", lat); else pass_cnt++;
    tot_cnt++; if (e !== 1'b0) $display("FAIL lat_err: got %b, required 0", e); else pass_cnt++;
    @(negedge PCLK);
    tot_cnt++; if (done !== 1'b0) $display("FAIL lat_done_pulse: got %b, required 0", done); else pass_cnt++;
    tot_cnt++; if (exp_q.size() != 0) $display("FAIL lat_apb_left: got %0d, required 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_write_job();
    int lat; logic e, ok;
    busy_n = 2; st_base = st_cnt;
    exp_apb(ADDR_DATA, 1'b1, 8'hA5);
    exp_apb(ADDR_CMD, 1'b1, 8'h80);
    for (int i = 0; i < 3; i++) exp_apb(ADDR_STATUS, 1'b0, 8'h00);
    start_job(1'b1, 8'hA5, 8'h80, 16'd0);
    wait_done(lat, e, ok);
    tot_cnt++; if (!ok) $display("FAIL wr_done_seen: got timeout, required done"); else pass_cnt++;
    tot_cnt++; if (e !== 1'b0) $display("FAIL wr_err: got %b, required 0", e); else pass_cnt++;
    tot_cnt++; if (st_cnt - st_base != 3) $display("FAIL wr_polls: got %0d, required 3", st_cnt - st_base); else pass_cnt++;
    tot_cnt++; if (exp_q.size() != 0) $display("FAIL wr_apb_left: got %0d, required 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_read_job();
    int lat; logic e, ok;
    logic [7:0] b[4];
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    wait_cyc = 1; busy_n = 0; st_base = st_cnt; dat_base = dat_cnt;
    exp_apb(ADDR_CMD, 1'b1, 8'h00);
    exp_apb(ADDR_STATUS, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      data_arr[i] = b[i];
      exp_apb(ADDR_DATA, 1'b0, 8'h00);
      rd_q.push_back(b[i]);
    end
    start_job(1'b0, 8'h00, 8'h00, 16'd4);
    wait_done(lat, e, ok);
    tot_cnt++; if (!ok) $display("FAIL rd_done_seen: got timeout, required done"); else pass_cnt++;
    tot_cnt++; if (e !== 1'b0) $display("FAIL rd_err: got %b, required 0", e); else pass_cnt++;
    tot_cnt++; if (rd_q.size() != 0) $display("FAIL rd_bytes_left_at_done: got %0d, required 0", rd_q.size()); else pass_cnt++;
    tot_cnt++; if (exp_q.size() != 0) $display("FAIL rd_apb_left: got %0d, required 0", exp_q.size()); else pass_cnt++;
    wait_cyc = 0;
  endtask

  task automatic test_stall();
    int lat; logic e, ok;
    logic [7:0] b[3];
    b = '{8'h5A, 8'hC3, 8'h7E};
    busy_n = 0; st_base = st_cnt; dat_base = dat_cnt;
    stall_at = byte_cnt + 1; stall_len = 10;
    exp_apb(ADDR_CMD, 1'b1, 8'h05);
    exp_apb(ADDR_STATUS, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      data_arr[i] = b[i];
      exp_apb(ADDR_DATA, 1'b0, 8'h00);
      rd_q.push_back(b[i]);
    end
    start_job(1'b0, 8'h00, 8'h05, 16'd3);
    wait_done(lat, e, ok);
    tot_cnt++; if (!ok) $display("FAIL stall_done_seen: got timeout, required done"); else pass_cnt++;
    tot_cnt++; if (lat != 32) $display("FAIL stall_latency: got %0d, required 32", lat); else pass_cnt++;
    tot_cnt++; if (rd_q.size() != 0) $display("FAIL stall_bytes_left: got %0d, required 0", rd_q.size()); else pass_cnt++;
    tot_cnt++; if (exp_q.size() != 0) $display("FAIL stall_apb_left: got %0d, required 0", exp_q.size()); else pass_cnt++;
    stall_at = -1;
  endtask

  task automatic test_timeout();
    int lat; logic e, ok;
    busy_n = 1000; st_base = st_cnt;
    exp_apb(ADDR_CMD, 1'b1, 8'h60);
    for (int i = 0; i < 8; i++) exp_apb(ADDR_STATUS, 1'b0, 8'h00);
    start_job(1'b0, 8'h00, 8'h60, 16'd2);
    wait_done(lat, e, ok);
    tot_cnt++; if (!ok) $display("FAIL to_done_seen: got timeout, required done"); else pass_cnt++;
    tot_cnt++; if (e !== 1'b1) $display("FAIL to_err: got %b, required 1", e); else pass_cnt++;
    tot_cnt++; if (st_cnt - st_base != 8) $display("FAIL to_polls: got %0d, required 8", st_cnt - st_base); else pass_cnt++;
    tot_cnt++; if (exp_q.size() != 0) $display("FAIL to_apb_left: got %0d, required 0", exp_q.size()); else pass_cnt++;
    busy_n = 0;
  endtask

  task automatic test_slverr();
    int lat; logic e, ok;
    busy_n = 0; st_base = st_cnt; err_en = 1'b1; err_addr = ADDR_CMD;
    exp_apb(ADDR_CMD, 1'b1, 8'h70);
    start_job(1'b0, 8'h00, 8'h70, 16'd1);
    wait_done(lat, e, ok);
    tot_cnt++; if (!ok) $display("FAIL se_done_seen: got timeout, required done"); else pass_cnt++;
    tot_cnt++; if (e !== 1'b1) $display("FAIL se_err: got %b, required 1", e); else pass_cnt++;
    repeat (10) @(negedge PCLK);
    tot_cnt++; if (st_cnt != st_base) $display("FAIL se_no_poll: got %0d polls, required 0", st_cnt - st_base); else pass_cnt++;
    tot_cnt++; if (exp_q.size() != 0) $display("FAIL se_apb_left: got %0d, required 0", exp_q.size()); else pass_cnt++;
    err_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat, n; logic e, ok, seen;
    wait_cyc = 1000;
    exp_apb(ADDR_CMD, 1'b1, 8'h40);
    start_job(1'b0, 8'h00, 8'h40, 16'd0);
    n = 0;
    while (!(PSEL && PENABLE) && n < 20) begin @(negedge PCLK); n++; end
    tot_cnt++; if (!(PSEL && PENABLE)) $display("FAIL rm_access_reached: got sel=%b en=%b, required 1 1", PSEL, PENABLE); else pass_cnt++;
    #2 PRESET = 1'b1;
    #1;
    tot_cnt++; if ({PSEL, PENABLE} !== 2'b00) $display("FAIL rm_psel_drop: got sel=%b en=%b, required 0 0", PSEL, PENABLE); else pass_cnt++;
    exp_q.delete();
    wait_cyc = 0;
    @(negedge PCLK);
    PRESET = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(negedge PCLK); if (done || err) seen = 1'b1; end
    tot_cnt++; if (seen !== 1'b0) $display("FAIL rm_no_done: got done/err pulse, required none"); else pass_cnt++;
    busy_n = 0; st_base = st_cnt; dat_base = dat_cnt;
    data_arr[0] = 8'h9C;
    exp_apb(ADDR_CMD, 1'b1, 8'h41);
    exp_apb(ADDR_STATUS, 1'b0, 8'h00);
    exp_apb(ADDR_DATA, 1'b0, 8'h00);
    rd_q.push_back(8'h9C);
    start_job(1'b0, 8'h00, 8'h41, 16'd1);
    wait_done(lat, e, ok);
    tot_cnt++; if (!ok || e !== 1'b0) $display("FAIL rm_next_job: got ok=%b err=%b, required 1 0", ok, e); else pass_cnt++;
    tot_cnt++; if (lat != 14) $display("FAIL rm_next_latency: got %0d, required 14", lat); else pass_cnt++;
    tot_cnt++; if (exp_q.size() != 0 || rd_q.size() != 0)
      $display("FAIL rm_next_left: got apb=%0d rd=%0d, required 0 0", exp_q.size(), rd_q.size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat; logic e, ok;
    busy_n = 0; st_base = st_cnt;
    exp_apb(ADDR_DATA, 1'b1, 8'h3C);
    exp_apb(ADDR_CMD, 1'b1, 8'h10);
    exp_apb(ADDR_STATUS, 1'b0, 8'h00);
    start_job(1'b1, 8'h3C, 8'h10, 16'd0);
    wait_done(lat, e, ok);
    tot_cnt++; if (!ok || e !== 1'b0) $display("FAIL b2b_first: got ok=%b err=%b, required 1 0", ok, e); else pass_cnt++;
    exp_apb(ADDR_CMD, 1'b1, 8'h20);
    exp_apb(ADDR_STATUS, 1'b0, 8'h00);
    start_job(1'b0, 8'h00, 8'h20, 16'd0);
    wait_done(lat, e, ok);
    tot_cnt++; if (!ok || e !== 1'b0) $display("FAIL b2b_second: got ok=%b err=%b, required 1 0", ok, e); else pass_cnt++;
    tot_cnt++; if (lat != 10) $display("FAIL b2b_second_latency: got %0d, required 10", lat); else pass_cnt++;
    tot_cnt++; if (exp_q.size() != 0) $display("FAIL b2b_apb_left: got %0d, required 0", exp_q.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_write_job();
    test_read_job();
    test_stall();
    test_timeout();
    test_slverr();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge PCLK);
    pass_cnt += mon_pass;
    tot_cnt  += mon_tot;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
